data_sram_resp: RTL and testbench



---
 rtl/data_sram_resp_pkg.sv | 34 +++
 rtl/data_sram_resp_bram.sv | 30 +++
 rtl/data_sram_resp.sv | 147 ++++++++++++++
 tb/tb_data_sram_resp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants, read-source encoding and byte-merge helper for the data-SRAM
// responder and its byte-enable RAM.
package data_sram_resp_pkg;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'h1FAF;

    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_NUM    = 16'hF020;
    localparam logic [15:0] OFF_SWITCH = 16'hF024;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;

    // Which registered source drives data_sram_rdata after an access.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } rsrc_t;

    function automatic logic [31:0] merge_be(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_resp_bram.sv
// Single-port synchronous RAM with per-byte write enables; the read port returns
// the word as it was before a same-cycle write (read-first).
module bram_be
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // No reset: dout holds its value whenever en is low, which the top relies on.
    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: decodes CPU data accesses into block RAM, a small MMIO
// register window (LED, NUM, SWITCH, TIMER) or an unmapped hole reading as zero.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] timer_out
);

    // Handshake: data_sram_en alone qualifies a request and there is no ready;
    // every request is accepted in the cycle it is presented and its read data
    // (old word for writes) appears on data_sram_rdata after exactly one edge.

    logic        access;
    logic        is_mmio;
    logic        is_ram;
    logic [15:0] offset;
    logic [31:0] mmio_rd;
    logic        led_we;
    logic        num_we;
    logic        timer_we;
    logic [31:0] led_next;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_dout;

    rsrc_t       src_q;
    logic [31:0] mmio_q;
    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [31:0] timer_q;

    logic        unused_bits;

    assign access  = data_sram_en & resetn;
    assign is_mmio = (data_sram_addr[31:16] == MMIO_BASE);
    assign is_ram  = (data_sram_addr[31:ADDR_W+2] == '0);
    assign offset  = {data_sram_addr[15:2], 2'b00};

    assign ram_en = access & is_ram;
    assign ram_we = ram_en ? data_sram_wen : 4'b0000;

    bram_be #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (data_sram_addr[ADDR_W+1:2]),
        .din  (data_sram_wdata),
        .dout (ram_dout)
    );

    // MMIO read value is taken before this edge's register updates.
    always_comb begin
        mmio_rd = 32'h0;
        case (offset)
            OFF_LED:    mmio_rd = {16'h0, led_q};
            OFF_NUM:    mmio_rd = num_q;
            OFF_SWITCH: mmio_rd = {24'h0, switch_in};
            OFF_TIMER:  mmio_rd = timer_q;
            default:    mmio_rd = 32'h0;
        endcase
    end

    always_comb begin
        led_we   = 1'b0;
        num_we   = 1'b0;
        timer_we = 1'b0;
        if (access && is_mmio && (data_sram_wen != 4'b0000)) begin
            led_we   = (offset == OFF_LED);
            num_we   = (offset == OFF_NUM);
            timer_we = (offset == OFF_TIMER);
        end
    end

    assign led_next = merge_be({16'h0, led_q}, data_sram_wdata, data_sram_wen);

    // Read-source select is registered with the RAM read so the mux lines up
    // with the RAM's one-cycle latency.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            src_q  <= SRC_ZERO;
            mmio_q <= 32'h0;
        end else if (access) begin
            if (is_mmio) begin
                src_q <= SRC_MMIO;
            end else if (is_ram) begin
                src_q <= SRC_RAM;
            end else begin
                src_q <= SRC_ZERO;
            end
            mmio_q <= mmio_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_q <= 16'h0;
            num_q <= 32'h0;
        end else begin
            if (led_we) begin
                led_q <= led_next[15:0];
            end
            if (num_we) begin
                num_q <= merge_be(num_q, data_sram_wdata, data_sram_wen);
            end
        end
    end

    // A timer write replaces the enabled bytes and suppresses that cycle's increment.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer_q <= 32'h0;
        end else if (timer_we) begin
            timer_q <= merge_be(timer_q, data_sram_wdata, data_sram_wen);
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    always_comb begin
        data_sram_rdata = 32'h0;
        case (src_q)
            SRC_RAM:  data_sram_rdata = ram_dout;
            SRC_MMIO: data_sram_rdata = mmio_q;
            default:  data_sram_rdata = 32'h0;
        endcase
    end

    assign led_out   = led_q;
    assign timer_out = timer_q;

    assign unused_bits = ^{data_sram_addr[1:0], led_next[31:16]};

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: RAM byte lanes, read-first, MMIO registers,
// timer load/wrap and reset gating, checked with immediate assertions.
module tb_data_sram_resp;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic [31:0] timer_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    localparam logic [31:0] A_LED    = 32'h1FAF_F000;
    localparam logic [31:0] A_NUM    = 32'h1FAF_F020;
    localparam logic [31:0] A_SWITCH = 32'h1FAF_F024;
    localparam logic [31:0] A_TIMER  = 32'h1FAF_E000;

    data_sram_resp dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .timer_out       (timer_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    task automatic idle();
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_rdata(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, data_sram_rdata, e);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        switch_in = 8'h00;
        idle();

        // 1. Reset, then first read and timer start
        step(); step(); step();
        check("rst_rdata", data_sram_rdata, 32'h0);
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_timer", timer_out, 32'h0);
        resetn = 1'b1;
        drive(4'h0, A_LED, 32'h0);
        exp_q.push_back(32'h0);
        step();
        check_rdata("led_read_after_rst");
        check("led_after_rst", {16'h0, led_out}, 32'h0);
        check("timer_first", timer_out, 32'h1);

        // 2. Byte-lane write
        drive(4'hF, 32'h0000_0010, 32'h1122_3344);
        step();
        drive(4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
        exp_q.push_back(32'h1122_3344);
        step();
        check_rdata("lane_write_old");
        drive(4'h0, 32'h0000_0010, 32'h0);
        exp_q.push_back(32'h11BB_33DD);
        step();
        check_rdata("lane_merge");

        // 3. Read-first and back-to-back
        drive(4'hF, 32'h0000_0020, 32'h0);
        step();
        drive(4'hF, 32'h0000_0024, 32'h1234_5678);
        step();
        drive(4'hF, 32'h0000_0000, 32'hCAFE_F00D);
        step();
        drive(4'hF, 32'h0000_0020, 32'hDEAD_BEEF);
        exp_q.push_back(32'h0);
        step();
        check_rdata("read_first_old");
        drive(4'h0, 32'h0000_0020, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        check_rdata("read_after_write");
        drive(4'h0, 32'h0000_0024, 32'h0);
        exp_q.push_back(32'h1234_5678);
        step();
        check_rdata("b2b_24");
        drive(4'h0, 32'h0000_0020, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        check_rdata("b2b_20");
        idle();
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        check_rdata("hold_when_idle");

        // 4. Unmapped and read-only
        switch_in = 8'hA5;
        drive(4'hF, 32'h0040_0000, 32'h1234_5678);
        exp_q.push_back(32'h0);
        step();
        check_rdata("unmapped_write_rdata");
        drive(4'hF, A_SWITCH, 32'h1234_5678);
        step();
        drive(4'h0, 32'h0040_0000, 32'h0);
        exp_q.push_back(32'h0);
        step();
        check_rdata("unmapped_read");
        drive(4'h0, A_SWITCH, 32'h0);
        exp_q.push_back(32'h0000_00A5);
        step();
        check_rdata("switch_read");
        drive(4'h0, 32'h0000_0000, 32'h0);
        exp_q.push_back(32'hCAFE_F00D);
        step();
        check_rdata("ram_word0_untouched");

        // LED and NUM registers with byte enables
        drive(4'hF, A_LED, 32'hFFFF_1234);
        step();
        check("led_full", {16'h0, led_out}, 32'h0000_1234);
        drive(4'b0010, A_LED, 32'h0000_AB00);
        step();
        check("led_partial", {16'h0, led_out}, 32'h0000_AB34);
        drive(4'h0, A_LED, 32'h0);
        exp_q.push_back(32'h0000_AB34);
        step();
        check_rdata("led_read");
        drive(4'hF, A_NUM, 32'hA5A5_0001);
        step();
        drive(4'b0011, A_NUM, 32'h0000_BEEF);
        step();
        drive(4'h0, A_NUM, 32'h0);
        exp_q.push_back(32'hA5A5_BEEF);
        step();
        check_rdata("num_read");

        // 5. Timer load, wrap, partial write, read-before-update
        drive(4'hF, A_TIMER, 32'hFFFF_FFFE);
        step();
        check("timer_load", timer_out, 32'hFFFF_FFFE);
        idle();
        step();
        check("timer_max", timer_out, 32'hFFFF_FFFF);
        step();
        check("timer_wrap", timer_out, 32'h0);
        drive(4'b1000, A_TIMER, 32'h7F00_0000);
        step();
        check("timer_partial", timer_out, 32'h7F00_0000);
        drive(4'h0, A_TIMER, 32'h0);
        exp_q.push_back(32'h7F00_0000);
        step();
        check_rdata("timer_read_pre_edge");
        check("timer_after_read", timer_out, 32'h7F00_0001);

        // 6. Reset coinciding with a write
        resetn = 1'b0;
        drive(4'hF, A_LED, 32'h0000_FFFF);
        step();
        check("midrst_led", {16'h0, led_out}, 32'h0);
        check("midrst_rdata", data_sram_rdata, 32'h0);
        check("midrst_timer", timer_out, 32'h0);
        resetn = 1'b1;
        idle();
        step();
        check("post_rst_led", {16'h0, led_out}, 32'h0);
        drive(4'h0, A_NUM, 32'h0);
        exp_q.push_back(32'h0);
        step();
        check_rdata("post_rst_num");
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
